fbuf_write_arbiter: RTL and testbench

Shares the single framebuffer write port between two pixel requesters, such as the test pattern generator and a drawing engine. It also contains a built-in clear engine that fills the whole frame with one color. The block sits between the pixel producers and the framebuffer BRAM write port. It drives the same address/color/write-enable triple that the framebuffer already consumes.

---
 rtl/fbuf_pkg.sv | 18 +
 rtl/fbuf_write_arbiter_if.sv | 47 ++++
 rtl/fbuf_clear_sequencer.sv | 46 ++++
 rtl/fbuf_write_arbiter.sv | 118 +++++++++++
 tb/tb_fbuf_write_arbiter.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/fbuf_pkg.sv
// Shared framebuffer definitions: default bus widths, arbiter state encoding
// and the frame pixel count helper used at elaboration time.
package fbuf_pkg;

  localparam int unsigned FBUF_ADDR_WIDTH = 16;
  localparam int unsigned FBUF_DATA_WIDTH = 8;

  typedef enum logic [0:0] {
    StArb,
    StClear
  } arb_state_e;

  function automatic int unsigned frame_pixels(input int unsigned width,
                                               input int unsigned height);
    return width * height;
  endfunction

endpackage

// File: rtl/fbuf_write_arbiter_if.sv
// Bundles the two pixel requester handshakes, the clear control and the
// framebuffer write triple.
//   master : pixel producers / clear controller side
//   slave  : the write arbiter itself
interface fbuf_write_arbiter_if #(
  parameter int unsigned FBUF_ADDR_WIDTH = 16,
  parameter int unsigned FBUF_DATA_WIDTH = 8
);
  logic                       req0_valid;
  logic [FBUF_ADDR_WIDTH-1:0] req0_address;
  logic [FBUF_DATA_WIDTH-1:0] req0_color;
  logic                       req0_ready;

  logic                       req1_valid;
  logic [FBUF_ADDR_WIDTH-1:0] req1_address;
  logic [FBUF_DATA_WIDTH-1:0] req1_color;
  logic                       req1_ready;

  logic                       clear_start;
  logic [FBUF_DATA_WIDTH-1:0] clear_color;
  logic                       clear_busy;

  logic [FBUF_ADDR_WIDTH-1:0] pixel_fbuf_address;
  logic [FBUF_DATA_WIDTH-1:0] pixel_fbuf_color;
  logic                       pixel_fbuf_wr_en;

  modport master (
    output req0_valid, req0_address, req0_color,
    input  req0_ready,
    output req1_valid, req1_address, req1_color,
    input  req1_ready,
    output clear_start, clear_color,
    input  clear_busy,
    input  pixel_fbuf_address, pixel_fbuf_color, pixel_fbuf_wr_en
  );

  modport slave (
    input  req0_valid, req0_address, req0_color,
    output req0_ready,
    input  req1_valid, req1_address, req1_color,
    output req1_ready,
    input  clear_start, clear_color,
    output clear_busy,
    output pixel_fbuf_address, pixel_fbuf_color, pixel_fbuf_wr_en
  );

endinterface

// File: rtl/fbuf_clear_sequencer.sv
// Frame fill sequencer: holds the fill address counter and the latched fill
// color, and flags when the counter sits on the last pixel of the frame.
//   clk, rst_n : clock, asynchronous active-low reset
//   start_i    : reload counter to 0 and latch color_i
//   step_i     : advance counter by one
//   color_i    : fill color to latch on start_i
//   addr_o     : current fill address
//   color_o    : latched fill color
//   done_o     : addr_o is the last pixel of the frame
module fbuf_clear_sequencer #(
  parameter int unsigned FRAME_PIXELS    = 19200,
  parameter int unsigned FBUF_ADDR_WIDTH = 16,
  parameter int unsigned FBUF_DATA_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start_i,
  input  logic                       step_i,
  input  logic [FBUF_DATA_WIDTH-1:0] color_i,
  output logic [FBUF_ADDR_WIDTH-1:0] addr_o,
  output logic [FBUF_DATA_WIDTH-1:0] color_o,
  output logic                       done_o
);

  localparam logic [FBUF_ADDR_WIDTH-1:0] LAST_ADDR = FBUF_ADDR_WIDTH'(FRAME_PIXELS - 1);

  logic [FBUF_ADDR_WIDTH-1:0] cnt_q;
  logic [FBUF_DATA_WIDTH-1:0] color_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      color_q <= '0;
    end else if (start_i) begin
      cnt_q   <= '0;
      color_q <= color_i;
    end else if (step_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign addr_o  = cnt_q;
  assign color_o = color_q;
  assign done_o  = (cnt_q == LAST_ADDR);

endmodule

// File: rtl/fbuf_write_arbiter.sv
// Framebuffer write port arbiter: round-robin between two pixel requesters,
// with a built-in clear engine that fills the whole frame with one color.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : requester handshakes, clear control/status and the
//                registered framebuffer write triple (slave modport)
module fbuf_write_arbiter #(
  parameter int unsigned FRAME_WIDTH     = 160,
  parameter int unsigned FRAME_HEIGHT    = 120,
  parameter int unsigned FBUF_ADDR_WIDTH = fbuf_pkg::FBUF_ADDR_WIDTH,
  parameter int unsigned FBUF_DATA_WIDTH = fbuf_pkg::FBUF_DATA_WIDTH
) (
  input logic                 clk,
  input logic                 rst_n,
  fbuf_write_arbiter_if.slave bus
);
  import fbuf_pkg::*;

  localparam int unsigned FRAME_PIXELS = frame_pixels(FRAME_WIDTH, FRAME_HEIGHT);
  // One extra bit so a frame filling the whole address space still compares correctly.
  localparam logic [FBUF_ADDR_WIDTH:0] PIXEL_LIMIT = (FBUF_ADDR_WIDTH + 1)'(FRAME_PIXELS);

  arb_state_e                 state_q, state_d;
  logic                       prio_q, prio_d;  // 0: requester 0 wins a tie
  logic [FBUF_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [FBUF_DATA_WIDTH-1:0] color_q, color_d;
  logic                       wr_en_q, wr_en_d;

  logic                       grant0, grant1;
  logic                       seq_start, seq_step, seq_done;
  logic [FBUF_ADDR_WIDTH-1:0] seq_addr;
  logic [FBUF_DATA_WIDTH-1:0] seq_color;

  fbuf_clear_sequencer #(
    .FRAME_PIXELS    (FRAME_PIXELS),
    .FBUF_ADDR_WIDTH (FBUF_ADDR_WIDTH),
    .FBUF_DATA_WIDTH (FBUF_DATA_WIDTH)
  ) u_clear_seq (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (seq_start),
    .step_i  (seq_step),
    .color_i (bus.clear_color),
    .addr_o  (seq_addr),
    .color_o (seq_color),
    .done_o  (seq_done)
  );

  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    addr_d    = addr_q;
    color_d   = color_q;
    wr_en_d   = 1'b0;
    seq_start = 1'b0;
    seq_step  = 1'b0;
    grant0    = 1'b0;
    grant1    = 1'b0;

    case (state_q)
      StArb: begin
        if (bus.clear_start) begin
          seq_start = 1'b1;
          state_d   = StClear;
        end else if (rst_n) begin
          // A lone valid requester wins regardless of priority.
          grant0 = bus.req0_valid && (!bus.req1_valid || !prio_q);
          grant1 = bus.req1_valid && (!bus.req0_valid || prio_q);
          if (grant0) begin
            prio_d  = 1'b1;
            addr_d  = bus.req0_address;
            color_d = bus.req0_color;
            // Out-of-frame pixels are consumed but never written.
            wr_en_d = ({1'b0, bus.req0_address} < PIXEL_LIMIT);
          end else if (grant1) begin
            prio_d  = 1'b0;
            addr_d  = bus.req1_address;
            color_d = bus.req1_color;
            wr_en_d = ({1'b0, bus.req1_address} < PIXEL_LIMIT);
          end
        end
      end
      StClear: begin
        seq_step = 1'b1;
        addr_d   = seq_addr;
        color_d  = seq_color;
        wr_en_d  = 1'b1;
        if (seq_done) begin
          state_d = StArb;
        end
      end
      default: state_d = StArb;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StArb;
      prio_q  <= 1'b0;
      addr_q  <= '0;
      color_q <= '0;
      wr_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      addr_q  <= addr_d;
      color_q <= color_d;
      wr_en_q <= wr_en_d;
    end
  end

  assign bus.req0_ready         = grant0;
  assign bus.req1_ready         = grant1;
  assign bus.clear_busy         = (state_q == StClear);
  assign bus.pixel_fbuf_address = addr_q;
  assign bus.pixel_fbuf_color   = color_q;
  assign bus.pixel_fbuf_wr_en   = wr_en_q;

endmodule

// File: tb/tb_fbuf_write_arbiter.sv
// Directed bench for fbuf_write_arbiter at default frame size (160x120).
// Inputs change on the falling edge; outputs are observed on the falling edge.
module tb_fbuf_write_arbiter;

  localparam int unsigned N = 19200;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  fbuf_write_arbiter_if #(
    .FBUF_ADDR_WIDTH (16),
    .FBUF_DATA_WIDTH (8)
  ) bus ();

  fbuf_write_arbiter #(
    .FRAME_WIDTH     (160),
    .FRAME_HEIGHT    (120),
    .FBUF_ADDR_WIDTH (16),
    .FBUF_DATA_WIDTH (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int n0;
    int n1;
    int bad_wr;
    int bad_busy;
    int bad_rdy;
    int busy_cycles;
    logic g;

    checks = 0;
    errors = 0;
    n0 = 0;
    n1 = 0;
    bad_wr = 0;
    bad_busy = 0;
    bad_rdy = 0;
    busy_cycles = 0;

    bus.req0_valid   = 1'b0;
    bus.req0_address = '0;
    bus.req0_color   = '0;
    bus.req1_valid   = 1'b0;
    bus.req1_address = '0;
    bus.req1_color   = '0;
    bus.clear_start  = 1'b0;
    bus.clear_color  = '0;
    rst_n = 1'b1;
    #3 rst_n = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_addr", 32'(bus.pixel_fbuf_address), 0);
    check("rst_color", 32'(bus.pixel_fbuf_color), 0);
    check("rst_wr_en", 32'(bus.pixel_fbuf_wr_en), 0);
    check("rst_busy", 32'(bus.clear_busy), 0);
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    #1;
    check("rst_ready0", 32'(bus.req0_ready), 0);
    check("rst_ready1", 32'(bus.req1_ready), 0);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("idle_wr_en", 32'(bus.pixel_fbuf_wr_en), 0);

    // Single requester: addr 5, color A3
    bus.req0_valid   = 1'b1;
    bus.req0_address = 16'd5;
    bus.req0_color   = 8'hA3;
    #1;
    check("single_ready0", 32'(bus.req0_ready), 1);
    tick();
    bus.req0_valid = 1'b0;
    check("single_addr", 32'(bus.pixel_fbuf_address), 5);
    check("single_color", 32'(bus.pixel_fbuf_color), 32'h A3);
    check("single_wr_en", 32'(bus.pixel_fbuf_wr_en), 1);
    tick();
    check("single_wr_once", 32'(bus.pixel_fbuf_wr_en), 0);

    // Last in-frame address, req0 alone (priority now at req1)
    bus.req0_valid   = 1'b1;
    bus.req0_address = 16'd19199;
    bus.req0_color   = 8'h42;
    #1;
    check("last_ready0", 32'(bus.req0_ready), 1);
    tick();
    bus.req0_valid = 1'b0;
    check("last_addr", 32'(bus.pixel_fbuf_address), 19199);
    check("last_wr_en", 32'(bus.pixel_fbuf_wr_en), 1);

    // Out of range on req1: consumed, never written
    bus.req1_valid   = 1'b1;
    bus.req1_address = 16'd19200;
    bus.req1_color   = 8'h99;
    #1;
    check("oor_ready1", 32'(bus.req1_ready), 1);
    tick();
    bus.req1_valid = 1'b0;
    check("oor_wr_en", 32'(bus.pixel_fbuf_wr_en), 0);

    // Contention: priority back at req0 -> grants 0,1,0,1,0,1
    for (int i = 0; i < 6; i++) begin
      g = (i % 2) == 1;
      bus.req0_valid   = 1'b1;
      bus.req0_address = 16'(100 + n0);
      bus.req0_color   = 8'(8'h10 + n0);
      bus.req1_valid   = 1'b1;
      bus.req1_address = 16'(200 + n1);
      bus.req1_color   = 8'(8'h20 + n1);
      #1;
      check("cont_ready0", 32'(bus.req0_ready), 32'(!g));
      check("cont_ready1", 32'(bus.req1_ready), 32'(g));
      tick();
      check("cont_wr_en", 32'(bus.pixel_fbuf_wr_en), 1);
      if (g) begin
        check("cont_addr", 32'(bus.pixel_fbuf_address), 32'(200 + n1));
        check("cont_color", 32'(bus.pixel_fbuf_color), 32'(8'h20 + n1));
        n1++;
      end else begin
        check("cont_addr", 32'(bus.pixel_fbuf_address), 32'(100 + n0));
        check("cont_color", 32'(bus.pixel_fbuf_color), 32'(8'h10 + n0));
        n0++;
      end
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    tick();
    check("cont_idle_wr_en", 32'(bus.pixel_fbuf_wr_en), 0);

    // Full clear with req0 pending
    bus.req0_valid   = 1'b1;
    bus.req0_address = 16'd7;
    bus.req0_color   = 8'h55;
    bus.clear_start  = 1'b1;
    bus.clear_color  = 8'h1C;
    #1;
    check("clr_start_ready0", 32'(bus.req0_ready), 0);
    tick();
    bus.clear_start = 1'b0;
    bus.clear_color = 8'hE7;
    #1;
    check("clr_busy_first", 32'(bus.clear_busy), 1);
    check("clr_ready0_first", 32'(bus.req0_ready), 0);
    busy_cycles = 1;
    for (int a = 0; a < int'(N); a++) begin
      if (a == 9000) bus.clear_color = 8'h3B;
      if (a == 500) bus.clear_start = 1'b1;
      if (a == 501) bus.clear_start = 1'b0;
      tick();
      if (!(bus.pixel_fbuf_wr_en === 1'b1 && 32'(bus.pixel_fbuf_address) === 32'(a)
            && bus.pixel_fbuf_color === 8'h1C)) bad_wr++;
      if (bus.clear_busy !== (a != int'(N) - 1)) bad_busy++;
      if (bus.req0_ready !== (a == int'(N) - 1)) bad_rdy++;
      if (bus.clear_busy === 1'b1) busy_cycles++;
    end
    check("clr_bad_writes", 32'(bad_wr), 0);
    check("clr_bad_busy", 32'(bad_busy), 0);
    check("clr_bad_ready", 32'(bad_rdy), 0);
    check("clr_busy_cycles", 32'(busy_cycles), N);
    tick();
    bus.req0_valid = 1'b0;
    check("post_clr_addr", 32'(bus.pixel_fbuf_address), 7);
    check("post_clr_color", 32'(bus.pixel_fbuf_color), 32'h55);
    check("post_clr_wr_en", 32'(bus.pixel_fbuf_wr_en), 1);

    // Reset mid-clear at address 1000
    bus.clear_start = 1'b1;
    bus.clear_color = 8'h3A;
    tick();
    bus.clear_start = 1'b0;
    for (int a = 0; a <= 1000; a++) tick();
    check("mid_addr", 32'(bus.pixel_fbuf_address), 1000);
    bus.req1_valid   = 1'b1;
    bus.req1_address = 16'd9;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_addr", 32'(bus.pixel_fbuf_address), 0);
    check("mid_rst_color", 32'(bus.pixel_fbuf_color), 0);
    check("mid_rst_wr_en", 32'(bus.pixel_fbuf_wr_en), 0);
    check("mid_rst_busy", 32'(bus.clear_busy), 0);
    check("mid_rst_ready1", 32'(bus.req1_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.req1_valid = 1'b0;
    tick();
    check("no_resume_busy", 32'(bus.clear_busy), 0);
    check("no_resume_wr_en", 32'(bus.pixel_fbuf_wr_en), 0);
    bus.clear_start = 1'b1;
    bus.clear_color = 8'h66;
    tick();
    bus.clear_start = 1'b0;
    check("restart_busy", 32'(bus.clear_busy), 1);
    tick();
    check("restart_addr0", 32'(bus.pixel_fbuf_address), 0);
    check("restart_color", 32'(bus.pixel_fbuf_color), 32'h66);
    check("restart_wr_en", 32'(bus.pixel_fbuf_wr_en), 1);
    tick();
    check("restart_addr1", 32'(bus.pixel_fbuf_address), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
